// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state types for the UART; UART_PARITY_EN adds the even-parity bit.
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: rx synchroniser and receive FSM; parity checked only when UART_PARITY_EN is defined.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 perr_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;

    assign rx_s    = sync_q[1];
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign perr_o  = perr_q;

    // two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_i};
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    // bit timing: confirm start at half a bit, then sample every full bit from that mid-point
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + IW'(1);
                if (idx_q == IDX_LAST) state_d = PARITY_EN ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (cnt_q == LAST) begin
                cnt_d   = '0;
                par_d   = rx_s;
                state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == LAST) begin
                cnt_d = '0;
                if (rx_s) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = PARITY_EN & (par_q != ^shift_q);
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                cnt_d = '0;
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART, inline TX FSM plus uart_rx_unit; UART_PARITY_EN selects 8E1, else 8N1.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 115200,
    parameter int CLK_FREQ = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_busy,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data,
    output logic       parity_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    assign tx           = tx_q;
    assign uart_tx_busy = busy_q;

    // transmit registers; tx and busy are registered so the pin never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // frame sequencing; requests outside IDLE are dropped, and tx/busy follow the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            TX_IDLE: if (uart_tx_en) begin
                state_d = TX_START;
                data_d  = uart_tx_data;
            end
            TX_START: if (cnt_q == LAST) begin
                state_d = TX_DATA;
                idx_d   = '0;
            end
            TX_DATA: if (cnt_q == LAST) begin
                idx_d = idx_q + IW'(1);
                if (idx_q == IDX_LAST) state_d = PARITY_EN ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (cnt_q == LAST) state_d = TX_STOP;
            TX_STOP:   if (cnt_q == LAST) state_d = TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
        if (state_q != TX_IDLE) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        busy_d = state_d != TX_IDLE;
        tx_d   = (state_d == TX_START)  ? 1'b0 :
                 (state_d == TX_DATA)   ? data_d[idx_d] :
                 (state_d == TX_PARITY) ? ^data_d : 1'b1;
    end

    uart_rx_unit #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx),
        .valid_o(uart_rx_valid),
        .data_o (uart_rx_data),
        .perr_o (parity_error)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: scoreboard bench for uart_transceiver, loopback plus directly driven rx frames.
module tb_uart_transceiver;

    localparam int CPB = 500_000 / 115200;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b1;
    logic       rx;
    logic       tx;
    logic       uart_tx_en = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       uart_tx_busy;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       parity_error;

    int         total = 0;
    int         bad = 0;
    logic [8:0] q[$];
    logic [8:0] e;
    logic [7:0] hold_exp;
    bit         hold = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;

    assign rx = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_transceiver #(
        .BIT_RATE(115200),
        .CLK_FREQ(500_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .tx           (tx),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data),
        .parity_error (parity_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every valid pulse must match the oldest expectation; data held, pulse one cycle
    always @(negedge clk) begin
        if (hold) begin
            chk("rx_data_held", uart_rx_data, hold_exp);
            chk("rx_valid_len", uart_rx_valid, 0);
        end
        hold = 1'b0;
        if (uart_rx_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("rx_data", uart_rx_data, e[7:0]);
                chk("rx_perr", parity_error, e[8]);
                hold_exp  = e[7:0];
                last_data = e[7:0];
                last_perr = e[8];
                hold      = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (uart_tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_busy_fall", uart_tx_busy, 0);
    endtask

    task automatic wait_rx();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rx_timeout", q.size(), 0);
    endtask

    task automatic send(input logic [7:0] d);
        wait_idle();
        uart_tx_en   = 1'b1;
        uart_tx_data = d;
        @(negedge clk);
        uart_tx_en = 1'b0;
        chk("tx_busy_rise", uart_tx_busy, 1);
        chk("tx_start_bit", tx, 0);
        q.push_back({1'b0, d});
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit(p);
        drive_bit(s);
        rx_drv = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", uart_tx_busy, 0);
        chk("rst_valid", uart_rx_valid, 0);
        chk("rst_data", uart_rx_data, 0);
        chk("rst_perr", parity_error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hA5);
        wait_idle();
        wait_rx();

        send(8'h3C);
        send(8'hFF);
        wait_rx();
        chk("b2b_last", uart_rx_data, 8'hFF);

        send(8'h5A);
        repeat (10) @(negedge clk);
        chk("busy_mid", uart_tx_busy, 1);
        uart_tx_en   = 1'b1;
        uart_tx_data = 8'h00;
        @(negedge clk);
        uart_tx_en = 1'b0;
        wait_rx();
        repeat (60) @(negedge clk);
        chk("ignored_req", uart_rx_data, 8'h5A);

        loop = 1'b0;
        repeat (4) @(negedge clk);
        q.push_back({PAR & (1'b0 != ^8'h01), 8'h01});
        drive_frame(8'h01, 1'b0, 1'b1);
        wait_rx();

        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        drive_frame(8'h77, ^8'h77, 1'b0);
        repeat (30) @(negedge clk);
        chk("ferr_data", uart_rx_data, last_data);
        chk("ferr_perr", parity_error, last_perr);
        q.push_back({1'b0, 8'h0F});
        drive_frame(8'h0F, ^8'h0F, 1'b1);
        wait_rx();

        loop = 1'b1;
        wait_idle();
        uart_tx_en   = 1'b1;
        uart_tx_data = 8'hC3;
        @(negedge clk);
        uart_tx_en = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", uart_tx_busy, 0);
        chk("midrst_data", uart_rx_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h55);
        wait_rx();
        chk("post_rst_data", uart_rx_data, 8'h55);
        repeat (60) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
